// File: rtl/memory_controller_interface.sv
// Shared MCI request/response types and the arbiter state encoding.
package memory_controller_interface;

  localparam int unsigned MciAddrWidth = 32;
  localparam int unsigned MciDataWidth = 128;

  typedef struct packed {
    logic                    valid;
    logic                    rw;     // 1 = write, 0 = read
    logic [MciAddrWidth-1:0] addr;
    logic [MciDataWidth-1:0] data;
  } mci_request_t;

  typedef struct packed {
    logic                    ready;
    logic [MciDataWidth-1:0] data;
  } mci_response_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } mci_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first active request at or after the pointer.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    logic [IdxW-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IdxW'((32'(ptr_i) + off) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/mci_arbiter.sv
// Round-robin arbiter sharing one MCI memory port between NUM_REQ requesters.
// Optional watchdog on the WAIT state is enabled by defining MCI_ARB_TIMEOUT_EN.
module mci_arbiter
  import memory_controller_interface::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  mci_request_t  [NUM_REQ-1:0]  i_req,
  output mci_response_t [NUM_REQ-1:0]  o_res,
  output mci_request_t                 mem_req,
  input  mci_response_t                mem_res,
  output logic                         o_busy,
  output logic          [NUM_REQ-1:0]  o_grant,
  output logic                         o_timeout_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : gen_bad_params
    $error("mci_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  mci_arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0]      grant_q, grant_d, req_valid, pick_grant;
  logic [IdxW-1:0]         idx_q, idx_d, rr_q, rr_d, pick_idx, rr_next;
  logic                    pick_any, rw_q, rw_d, wait_expired, done;
  logic [MciAddrWidth-1:0] addr_q, addr_d;
  logic [MciDataWidth-1:0] data_q, data_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = i_req[i].valid;
    end
  end

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_picker (
    .req_i  (req_valid),
    .ptr_i  (rr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // A ready seen in ISSUE completes the transaction exactly as in WAIT.
  assign done    = (state_q != StIdle) && mem_res.ready;
  assign rr_next = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StIssue;
      StIssue: state_d = mem_res.ready ? StIdle : StWait;
      StWait:  if (mem_res.ready || wait_expired) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy        = (state_q != StIdle);
    o_grant       = grant_q;
    mem_req.valid = (state_q == StIssue);
    mem_req.rw    = rw_q;
    mem_req.addr  = addr_q;
    mem_req.data  = data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_res[i].ready = done && grant_q[i];
      o_res[i].data  = mem_res.data;
    end
  end

  always_comb begin
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (state_q == StIdle) begin
      if (pick_any) begin
        grant_d = pick_grant;
        idx_d   = pick_idx;
        rw_d    = i_req[pick_idx].rw;
        addr_d  = i_req[pick_idx].addr;
        data_d  = i_req[pick_idx].data;
      end
    end else if (done || wait_expired) begin
      grant_d = '0;
      rr_d    = rr_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_q <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef MCI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // cnt_q holds the number of WAIT cycles already completed.
  assign wait_expired = (state_q == StWait) && !mem_res.ready &&
                        (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if (state_q == StWait && !mem_res.ready) begin
      cnt_d = cnt_q + 1'b1;
      if (wait_expired) err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_timeout_err = err_q;
`else
  assign wait_expired  = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mci_arbiter.sv
// Self-checking bench for mci_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model and a fake memory.
module tb_mci_arbiter;
  import memory_controller_interface::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 16;

  typedef struct packed {
    int unsigned  rid;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } item_t;

  logic                       clk = 1'b0;
  logic                       rst;
  mci_request_t  [N-1:0]      i_req;
  mci_response_t [N-1:0]      o_res;
  mci_request_t               mem_req;
  mci_response_t              mem_res;
  logic                       busy;
  logic [N-1:0]               grant;
  logic                       terr;

  always #5 clk = ~clk;

  mci_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (i_req),
    .o_res        (o_res),
    .mem_req      (mem_req),
    .mem_res      (mem_res),
    .o_busy       (busy),
    .o_grant      (grant),
    .o_timeout_err(terr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus controls
  int cyc = 0;
  bit rst_drive, random_fill, mem_never, stale_en, stale_force;
  int fixed_delay = -1;
  item_t scr_q[$];
  item_t rq_item [N];
  bit    rq_valid[N];
  bit    rq_done [N];

  // Reference model
  int    owner = -1;
  int    issue_cyc, idle_from, rr;
  item_t cur;
  bit    err_exp;
  logic [127:0] ref_mem [int unsigned];

  // Fake memory
  bit           mem_busy;
  int           mem_rdy_cyc;
  logic         mem_op_rw;
  logic [31:0]  mem_op_addr;
  logic [127:0] mem_op_data;
  logic [127:0] fmem [int unsigned];

  // Observation logs
  int           n_pulses, err_rise_cyc;
  int           rdy_cnt[N];
  int           rdy_cyc[N];
  logic [127:0] last_rdata[N];
  logic [31:0]  last_pulse_addr;
  int           pulse_owner[$];
  int           pulse_cyc[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] dflt(input logic [31:0] a);
    return {4{a ^ 32'h5a5a_0000}};
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push(input int unsigned rid, input logic rw, input logic [31:0] a,
                      input logic [127:0] d);
    item_t it;
    it.rid = rid; it.rw = rw; it.addr = a; it.data = d;
    scr_q.push_back(it);
  endtask

  task automatic clear_logs();
    n_pulses = 0;
    err_rise_cyc = -1;
    pulse_owner.delete();
    pulse_cyc.delete();
    for (int i = 0; i < N; i++) begin
      rdy_cnt[i] = 0; rdy_cyc[i] = -1; last_rdata[i] = '0;
    end
  endtask

  task automatic drive_reqs();
    int cnt;
    for (int i = 0; i < N; i++) begin
      cnt = 0;
      foreach (scr_q[k]) if (scr_q[k].rid == i) cnt++;
      if (random_fill && cnt < 2 && $urandom_range(3) == 0)
        push(i, 1'($urandom_range(1)), 32'($urandom_range(7)) << 6,
             {$urandom, $urandom, $urandom, $urandom});
      if (rq_done[i] || !rq_valid[i]) begin
        rq_done[i]  = 1'b0;
        rq_valid[i] = 1'b0;
        for (int k = 0; k < scr_q.size(); k++) begin
          if (scr_q[k].rid == i) begin
            rq_item[i]  = scr_q[k];
            rq_valid[i] = 1'b1;
            scr_q.delete(k);
            break;
          end
        end
      end
      i_req[i].valid = rq_valid[i];
      i_req[i].rw    = rq_item[i].rw;
      i_req[i].addr  = rq_item[i].addr;
      i_req[i].data  = rq_item[i].data;
    end
  endtask

  task automatic drive_mem();
    mem_res.ready = 1'b0;
    mem_res.data  = {$urandom, $urandom, $urandom, $urandom};
    if (mem_req.valid === 1'b1) begin
      mem_busy    = 1'b1;
      mem_op_rw   = mem_req.rw;
      mem_op_addr = mem_req.addr;
      mem_op_data = mem_req.data;
      mem_rdy_cyc = mem_never ? -1 :
                    cyc + ((fixed_delay >= 0) ? fixed_delay : int'($urandom_range(6)));
    end
    if (mem_busy && cyc == mem_rdy_cyc) begin
      mem_res.ready = 1'b1;
      mem_busy      = 1'b0;
      if (mem_op_rw) fmem[mem_op_addr] = mem_op_data;
      else mem_res.data = fmem.exists(mem_op_addr) ? fmem[mem_op_addr] : dflt(mem_op_addr);
    end else if (!mem_busy && owner < 0 &&
                 (stale_force || (stale_en && $urandom_range(7) == 0))) begin
      mem_res.ready = 1'b1;
    end
  endtask

  task automatic check_cycle();
    bit           exp_valid, exp_busy;
    logic [N-1:0] exp_grant, exp_rdy, got_rdy;
    logic [127:0] exp_rd;
    exp_valid = (owner >= 0) && (cyc == issue_cyc);
    exp_busy  = (owner >= 0) && (cyc >= issue_cyc);
    exp_grant = exp_busy ? N'(1) << owner : '0;
    exp_rdy   = (exp_busy && mem_res.ready) ? exp_grant : '0;
    for (int i = 0; i < N; i++) got_rdy[i] = o_res[i].ready;
    check("mem_valid", mem_req.valid, exp_valid);
    check("busy", busy, exp_busy);
    check("grant", grant, exp_grant);
    check("ready", got_rdy, exp_rdy);
    check("timeout_err", terr, err_exp);
    for (int i = 0; i < N; i++) check("route_data", o_res[i].data, mem_res.data);
    if (exp_busy) begin
      check("mem_rw", mem_req.rw, cur.rw);
      check("mem_addr", mem_req.addr, cur.addr);
      check("mem_data", mem_req.data, cur.data);
    end
    if (mem_req.valid === 1'b1) begin
      n_pulses++;
      pulse_cyc.push_back(cyc);
      pulse_owner.push_back(onehot_idx(grant));
      last_pulse_addr = mem_req.addr;
    end
    for (int i = 0; i < N; i++) begin
      if (o_res[i].ready === 1'b1) begin
        rdy_cnt[i]++; rdy_cyc[i] = cyc; last_rdata[i] = o_res[i].data;
      end
    end
    if (terr === 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc;
    if (exp_busy && mem_res.ready) begin
      if (!cur.rw) begin
        exp_rd = ref_mem.exists(cur.addr) ? ref_mem[cur.addr] : dflt(cur.addr);
        check("read_data", o_res[owner].data, exp_rd);
      end else begin
        ref_mem[cur.addr] = cur.data;
      end
      rq_done[owner] = 1'b1;
      rr        = (owner + 1) % N;
      owner     = -1;
      idle_from = cyc + 1;
    end
`ifdef MCI_ARB_TIMEOUT_EN
    else if (owner >= 0 && cyc == issue_cyc + TO) begin
      rr        = (owner + 1) % N;
      owner     = -1;
      idle_from = cyc + 1;
      err_exp   = 1'b1;
    end
`endif
  endtask

  task automatic claim();
    int j;
    if (owner < 0 && cyc >= idle_from) begin
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (rq_valid[j]) begin
          owner = j; cur = rq_item[j]; issue_cyc = cyc + 1;
          break;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    rst = rst_drive;
    drive_reqs();
    drive_mem();
    #1;
    check_cycle();
    if (rst_drive) begin
      owner = -1; rr = 0; idle_from = cyc + 1; err_exp = 1'b0;
    end else begin
      claim();
    end
  endtask

  task automatic reset_dut();
    rst_drive = 1'b1;
    step();
    rst_drive = 1'b0;
  endtask

  task automatic run_until_quiet(input int max_cycles, input string tag);
    bit quiet;
    quiet = 1'b0;
    for (int n = 0; n < max_cycles && !quiet; n++) begin
      step();
      quiet = (scr_q.size() == 0) && (owner < 0) && !mem_busy;
      for (int i = 0; i < N; i++) if (rq_valid[i]) quiet = 1'b0;
    end
    check(tag, quiet, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    rst     = 1'b1;
    i_req   = '0;
    mem_res = '0;
    clear_logs();
    repeat (3) @(posedge clk);

    // Reset values
    reset_dut();
    check("rst_mem_valid", mem_req.valid, 1'b0);
    check("rst_mem_addr", mem_req.addr, 32'h0);
    check("rst_mem_data", mem_req.data, 128'h0);
    check("rst_grant", grant, '0);
    check("rst_terr", terr, 1'b0);

    // Single read, memory delay 5
    fixed_delay = 5;
    clear_logs();
    t0 = cyc + 1;
    push(0, 1'b0, 32'h40, 128'h0);
    run_until_quiet(60, "single_done");
    check("single_pulses", n_pulses, 1);
    check("single_addr", last_pulse_addr, 32'h40);
    check("single_issue_lat", pulse_cyc[0] - t0, 1);
    check("single_rdy_lat", rdy_cyc[0] - pulse_cyc[0], 5);
    check("single_rdy0", rdy_cnt[0], 1);
    check("single_rdy1", rdy_cnt[1], 0);

    // Contention right after reset: requester 0 first, one idle bubble
    reset_dut();
    fixed_delay = 3;
    clear_logs();
    push(0, 1'b0, 32'h40, 128'h0);
    push(1, 1'b0, 32'hc0, 128'h0);
    run_until_quiet(60, "contend_done");
    check("contend_first", pulse_owner[0], 0);
    check("contend_second", pulse_owner[1], 1);
    check("contend_bubble", pulse_cyc[1] - rdy_cyc[0], 2);

    // Fairness with both held valid, plus write/readback of 0x80
    fixed_delay = 2;
    clear_logs();
    push(0, 1'b1, 32'h80, 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d);
    push(0, 1'b0, 32'h80, 128'h0);
    push(1, 1'b0, 32'h100, 128'h0);
    push(1, 1'b1, 32'h140, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    run_until_quiet(80, "fair_done");
    for (int k = 0; k < 4; k++) check("fair_order", pulse_owner[k], k % 2);
    check("fair_readback", last_rdata[0], 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d);

    // Stale memory ready while idle
    clear_logs();
    stale_force = 1'b1;
    repeat (3) step();
    stale_force = 1'b0;
    check("stale_rdy", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2], 0);
    check("stale_pulses", n_pulses, 0);

    // Random traffic
    fixed_delay = -1;
    clear_logs();
    random_fill = 1'b1;
    stale_en    = 1'b1;
    repeat (1500) step();
    random_fill = 1'b0;
    stale_en    = 1'b0;
    run_until_quiet(400, "rand_drain");
    check("rand_progress", n_pulses > 50, 1'b1);

    // Reset in WAIT: abort, late memory ready is not forwarded
    fixed_delay = 8;
    push(0, 1'b0, 32'h40, 128'h0);
    for (int n = 0; n < 20 && !(owner >= 0 && cyc > issue_cyc + 1); n++) step();
    check("rstwait_reached", owner >= 0 && cyc > issue_cyc + 1, 1'b1);
    for (int i = 0; i < N; i++) rq_valid[i] = 1'b0;
    reset_dut();
    clear_logs();
    step();
    check("rstwait_grant", grant, '0);
    check("rstwait_busy", busy, 1'b0);
    run_until_quiet(30, "rstwait_drain");
    check("rstwait_late_rdy", rdy_cnt[0], 0);

`ifdef MCI_ARB_TIMEOUT_EN
    // Memory never answers: watchdog fires after TO WAIT cycles and re-issues
    mem_never = 1'b1;
    clear_logs();
    push(1, 1'b0, 32'h200, 128'h0);
    repeat (45) step();
    check("to_err", terr, 1'b1);
    check("to_rise", err_rise_cyc - pulse_cyc[0], TO + 1);
    check("to_reissue", n_pulses >= 2, 1'b1);
    check("to_reissue_owner", pulse_owner[1], 1);
    for (int i = 0; i < N; i++) rq_valid[i] = 1'b0;
    reset_dut();
    mem_never = 1'b0;
    mem_busy  = 1'b0;
    step();
    check("to_clear", terr, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
